// File: rtl/halfband_pkg.sv
// Shared constants, state encoding and coefficient lookup for the half-band
// decimator/interpolator family.
package halfband_pkg;

  localparam int DW           = 20;
  localparam int CW           = 20;
  localparam int AW           = 45;
  localparam int ROUND_SHIFT  = 19;
  localparam int CENTER_SHIFT = 18;
  localparam int N_UNIQ       = 6;
  localparam int DL_A_LEN     = 12;
  localparam int DL_B_LEN     = 6;

  // Unique side-tap coefficients, scale 2^19; side taps sum to 0.5.
  localparam logic signed [CW-1:0] C0 = -20'sd183;
  localparam logic signed [CW-1:0] C1 =  20'sd1321;
  localparam logic signed [CW-1:0] C2 = -20'sd5334;
  localparam logic signed [CW-1:0] C3 =  20'sd16030;
  localparam logic signed [CW-1:0] C4 = -20'sd42993;
  localparam logic signed [CW-1:0] C5 =  20'sd162229;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    ROUND = 2'd2
  } hb_state_e;

  function automatic logic signed [CW-1:0] coef_sel(input logic [2:0] k);
    case (k)
      3'd0:    return C0;
      3'd1:    return C1;
      3'd2:    return C2;
      3'd3:    return C3;
      3'd4:    return C4;
      3'd5:    return C5;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/halfband_decim2_if.sv
// Sample-stream interface of the half-band decimator, with FSM state exposed
// for observation.
interface halfband_decim2_if;
  import halfband_pkg::*;

  // Handshake: clk_enable is a valid with no ready; a sample on filter_in is
  // consumed on every rising clk where it is high. ce_out is a one-cycle valid
  // for filter_out, also without back-pressure; filter_out holds in between.
  logic                 clk_enable;
  logic signed [DW-1:0] filter_in;
  logic signed [DW-1:0] filter_out;
  logic                 ce_out;
  logic                 overrun;
  hb_state_e            state;

  modport master (
    output clk_enable, filter_in,
    input  filter_out, ce_out, overrun, state
  );

  modport slave (
    input  clk_enable, filter_in,
    output filter_out, ce_out, overrun, state
  );

endinterface

// File: rtl/halfband_mac_core.sv
// Serial 6-step MAC with centre preload and round-half-up output stage.
// HB_DECIM_SAT_EN selects saturation of the result; otherwise it wraps to DW.
module halfband_mac_core
  import halfband_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic signed [DW-1:0] center,
  input  logic signed [DW:0]   tapsum,
  output logic [2:0]           tap_idx,
  output hb_state_e            state,
  output logic signed [DW-1:0] result,
  output logic                 result_vld
);

  localparam int PW = CW + DW + 1;
  localparam int RW = AW - ROUND_SHIFT;
  localparam logic signed [AW-1:0] ROUND_BIAS =
    {{(AW-ROUND_SHIFT){1'b0}}, 1'b1, {(ROUND_SHIFT-1){1'b0}}};

  logic signed [PW-1:0]  prod;
  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  acc_rnd;
  logic signed [RW-1:0]  r;
  logic signed [DW-1:0]  r_out;
  logic                  unused_bits;

  assign prod    = coef_sel(tap_idx) * tapsum;
  assign acc_rnd = acc + ROUND_BIAS;
  assign r       = acc_rnd[AW-1:ROUND_SHIFT];

`ifdef HB_DECIM_SAT_EN
  localparam logic signed [RW-1:0] R_MAX = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [RW-1:0] R_MIN = ~R_MAX;

  always_comb begin
    r_out = r[DW-1:0];
    if (r > R_MAX)      r_out = R_MAX[DW-1:0];
    else if (r < R_MIN) r_out = R_MIN[DW-1:0];
  end
  assign unused_bits = ^acc_rnd[ROUND_SHIFT-1:0];
`else
  assign r_out       = r[DW-1:0];
  assign unused_bits = ^{acc_rnd[ROUND_SHIFT-1:0], r[RW-1:DW]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tap_idx    <= '0;
      acc        <= '0;
      result     <= '0;
      result_vld <= 1'b0;
    end else begin
      result_vld <= 1'b0;
      case (state)
        IDLE: begin
          // The centre tap (0.5) is folded in as the accumulator preload.
          if (start) begin
            acc     <= {{(AW-DW-CENTER_SHIFT){center[DW-1]}}, center, {CENTER_SHIFT{1'b0}}};
            tap_idx <= '0;
            state   <= MAC;
          end
        end
        MAC: begin
          acc <= acc + {{(AW-PW){prod[PW-1]}}, prod};
          if (tap_idx == 3'(N_UNIQ-1)) state   <= ROUND;
          else                         tap_idx <= tap_idx + 3'd1;
        end
        ROUND: begin
          result     <= r_out;
          result_vld <= 1'b1;
          tap_idx    <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/halfband_decim2.sv
// 23-tap half-band decimate-by-2: polyphase delay lines and phase control
// around the shared MAC core. Optional saturation: HB_DECIM_SAT_EN.
module halfband_decim2
  import halfband_pkg::*;
(
  input logic              clk,
  input logic              reset_n,
  halfband_decim2_if.slave bus
);

  logic                 phase_b;
  logic signed [DW-1:0] dl_a [DL_A_LEN];
  logic signed [DW-1:0] dl_b [DL_B_LEN];
  logic signed [DW:0]   tapsum_sel;
  logic [2:0]           tap_idx;
  hb_state_e            core_state;
  logic                 core_idle;
  logic                 trigger;
  logic                 start;
  logic signed [DW-1:0] result;
  logic                 result_vld;

  assign core_idle = (core_state == IDLE);
  assign trigger   = bus.clk_enable && !phase_b;
  assign start     = trigger && core_idle;
  assign bus.state = core_state;

  always_comb begin
    tapsum_sel = '0;
    for (int k = 0; k < N_UNIQ; k++) begin
      if (tap_idx == 3'(k))
        tapsum_sel = {dl_a[k][DW-1], dl_a[k]}
                   + {dl_a[DL_A_LEN-1-k][DW-1], dl_a[DL_A_LEN-1-k]};
    end
  end

  // A trigger that finds the core busy is dropped, but the phase still
  // advances so the B/A alternation stays aligned with the sample stream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_b     <= 1'b1;
      bus.overrun <= 1'b0;
      for (int i = 0; i < DL_A_LEN; i++) dl_a[i] <= '0;
      for (int i = 0; i < DL_B_LEN; i++) dl_b[i] <= '0;
    end else if (bus.clk_enable) begin
      phase_b <= !phase_b;
      if (phase_b) begin
        dl_b[0] <= bus.filter_in;
        for (int i = 1; i < DL_B_LEN; i++) dl_b[i] <= dl_b[i-1];
      end else if (core_idle) begin
        dl_a[0] <= bus.filter_in;
        for (int i = 1; i < DL_A_LEN; i++) dl_a[i] <= dl_a[i-1];
      end else begin
        bus.overrun <= 1'b1;
      end
    end
  end

  halfband_mac_core u_mac (
    .clk        (clk),
    .rst_n      (reset_n),
    .start      (start),
    .center     (dl_b[DL_B_LEN-1]),
    .tapsum     (tapsum_sel),
    .tap_idx    (tap_idx),
    .state      (core_state),
    .result     (result),
    .result_vld (result_vld)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.filter_out <= '0;
      bus.ce_out     <= 1'b0;
    end else begin
      bus.ce_out <= result_vld;
      if (result_vld) bus.filter_out <= result;
    end
  end

endmodule

// File: tb/tb_halfband_decim2.sv
// Bench for halfband_decim2: directed vectors, a sample-history FIR model
// and a per-cycle compare of ce_out / filter_out / overrun.
module tb_halfband_decim2;
  import halfband_pkg::*;

  typedef logic signed [63:0] v64;

  localparam longint P   = 524287;
  localparam longint M   = -524288;
  localparam longint IMP = 262144;
`ifdef HB_DECIM_SAT_EN
  localparam longint SAT_EXP = 524287;
`else
  localparam longint SAT_EXP = -330253;
`endif

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   reset_n = 1'b1;
  longint cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  halfband_decim2_if bus();

  halfband_decim2 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- model / scoreboard state ----------------
  int     n_tests = 0;
  int     n_fail  = 0;
  longint a_hist[$];
  longint b_hist[$];
  bit     m_phase_b;
  longint m_last_trig;
  bit     m_overrun;
  logic signed [DW-1:0] exp_q[$];
  longint due_q[$];
  longint hold_val;
  longint cap_q[$];
  int     ce_cnt;
  bit     cmp_en = 1'b0;
  longint coef[6] = '{-183, 1321, -5334, 16030, -42993, 162229};

  task automatic chk(input string name, input v64 act, input v64 exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // y[m] = sum h[j]*x[n-j] over the 23-tap response, scaled by 2^19,
  // rounded half up, then clamped or wrapped to DW bits.
  function automatic longint model_output();
    longint y;
    logic signed [DW-1:0] t;
    y = 0;
    for (int k = 0; k < 12; k++)
      if (k < a_hist.size()) y += coef[(k < 6) ? k : 11 - k] * a_hist[k];
    if (b_hist.size() > 5) y += b_hist[5] * 262144;
    y = (y + 262144) >>> 19;
`ifdef HB_DECIM_SAT_EN
    if (y > 524287)  y = 524287;
    if (y < -524288) y = -524288;
`else
    t = y[DW-1:0];
    y = t;
`endif
    return y;
  endfunction

  task automatic model_accept(input longint v, input longint e_n);
    if (m_phase_b) begin
      b_hist.push_front(v);
    end else if (e_n - m_last_trig < 8) begin
      m_overrun = 1'b1;
    end else begin
      a_hist.push_front(v);
      m_last_trig = e_n;
      exp_q.push_back(DW'(model_output()));
      due_q.push_back(e_n + 9);
    end
    m_phase_b = !m_phase_b;
  endtask

  task automatic model_reset();
    a_hist.delete();
    b_hist.delete();
    exp_q.delete();
    due_q.delete();
    cap_q.delete();
    m_phase_b   = 1'b1;
    m_last_trig = -1000;
    m_overrun   = 1'b0;
    hold_val    = 0;
    ce_cnt      = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic drive(input longint v);
    @(negedge clk);
    bus.clk_enable = 1'b1;
    bus.filter_in  = DW'(v);
    @(posedge clk);
    model_accept(v, cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.clk_enable = 1'b0;
      bus.filter_in  = DW'($urandom_range(0, 1048575));
      @(posedge clk);
    end
  endtask

  // One B then one A sample, triggers spaced 10 clocks apart.
  task automatic pair(input longint b, input longint a);
    drive(b);
    idle(3);
    drive(a);
    idle(5);
  endtask

  task automatic check_caps(input string name, input longint lit[$]);
    chk({name, "_count"}, cap_q.size(), lit.size());
    for (int i = 0; i < lit.size(); i++)
      chk($sformatf("%s[%0d]", name, i), (i < cap_q.size()) ? cap_q[i] : 64'sd99999999, lit[i]);
  endtask

  function automatic longint sat_pattern(input int i);
    bit neg;
    neg = (i < 6) ? (i % 2 == 0) : ((11 - i) % 2 == 0);
    return neg ? M : P;
  endfunction

  // ---------------- compare process ----------------
  initial begin
    logic exp_ce;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        exp_ce = 1'b0;
        while (due_q.size() > 0 && due_q[0] < cyc) begin
          void'(due_q.pop_front());
          void'(exp_q.pop_front());
        end
        if (due_q.size() > 0 && due_q[0] == cyc) begin
          exp_ce   = 1'b1;
          hold_val = exp_q.pop_front();
          void'(due_q.pop_front());
        end
        chk("ce_out", bus.ce_out, exp_ce);
        chk("filter_out", bus.filter_out, hold_val);
        chk("overrun", bus.overrun, m_overrun);
        if (bus.ce_out) begin
          cap_q.push_back(bus.filter_out);
          ce_cnt++;
        end
      end
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    longint lit[$];
    int     w;
    bus.clk_enable = 1'b0;
    bus.filter_in  = '0;

    do_reset();
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_filter_out", bus.filter_out, 0);
    chk("rst_ce_out", bus.ce_out, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_state", bus.state, IDLE);

    // impulse on the even (A) phase walks out the side-tap coefficients
    do_reset();
    pair(0, IMP);
    repeat (12) pair(0, 0);
    idle(12);
    lit = '{-91, 661, -2667, 8015, -21496, 81115, 81115, -21496, 8015, -2667, 661, -91, 0};
    check_caps("imp_a", lit);

    // impulse on the odd (B) phase appears only through the centre tap
    do_reset();
    pair(IMP, 0);
    repeat (7) pair(0, 0);
    idle(12);
    lit = '{0, 0, 0, 0, 0, 131072, 0, 0};
    check_caps("imp_b", lit);

    // DC gain
    do_reset();
    repeat (14) pair(100000, 100000);
    idle(12);
    chk("dc_count", cap_q.size(), 14);
    chk("dc_first", (cap_q.size() > 0)  ? cap_q[0]  : 64'sd0, -35);
    chk("dc_settled11", (cap_q.size() > 11) ? cap_q[11] : 64'sd0, 99999);
    chk("dc_settled13", (cap_q.size() > 13) ? cap_q[13] : 64'sd0, 99999);

    // overrun: second trigger 5 clocks after the first is dropped
    do_reset();
    drive(0);
    idle(3);
    drive(IMP);
    drive(0);
    idle(3);
    drive(IMP);
    idle(5);
    repeat (3) pair(0, 0);
    idle(12);
    lit = '{-91, 661, -2667, 8015};
    check_caps("overrun_seq", lit);
    @(negedge clk);
    chk("overrun_sticky", bus.overrun, 1);

    // full-scale pattern matched to coefficient signs
    do_reset();
    for (int i = 0; i < 12; i++) pair(P, sat_pattern(i));
    idle(12);
    chk("sat_count", cap_q.size(), 12);
    chk("sat_value", (cap_q.size() > 11) ? cap_q[11] : 64'sd0, SAT_EXP);

    // reset in the middle of a MAC run aborts it silently
    drive(P);
    idle(1);
    drive(P);
    idle(3);
    #1;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(15);
    @(negedge clk);
    chk("abort_ce_cnt", ce_cnt, 0);
    chk("abort_filter_out", bus.filter_out, 0);
    chk("abort_overrun", bus.overrun, 0);
    pair(0, IMP);
    idle(12);
    lit = '{-91};
    check_caps("after_abort", lit);

    w = 0;
    while (due_q.size() > 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (due_q.size() > 0) chk("drain_timeout", due_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/halfband_decim2.md
Name: halfband_decim2

Overview:
- Polyphase half-band decimate-by-2 FIR for the receive/ADC path. It is the counterpart of the DAC-path half-band interpolator.
- The filter has 23 taps: 12 symmetric non-zero side taps (6 unique coefficients) plus a centre tap of 0.5.
- The side taps run through a serial 6-cycle MAC. One output is produced per input pair.

Parameters:
- DW, 20, input/output sample width (signed)
- CW, 20, coefficient width (signed, scale 2^19)
- AW, 45, accumulator width

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- clk_enable  in  1  input sample strobe; filter_in accepted on rising clk when high
- filter_in  in  DW  signed input sample
- filter_out  out  DW  signed decimated output, held between updates
- ce_out  out  1  one-cycle strobe, high in the cycle filter_out presents a new value
- overrun  out  1  sticky error flag; set when a trigger sample arrives while busy

Behaviour:
- Reset (async, reset_n=0):
  - phase = B; delay lines, acc, filter_out, ce_out, overrun = 0; FSM = IDLE.
- Phase toggles on every accepted sample (B, A, B, A, ...). The first sample after reset is B (odd).
- Phase-B sample: shifts into odd line dlB[0..5], 6 deep.
- Phase-A sample: the trigger.
  - Shifts into even line dlA[0..11].
  - Latches center_reg <= dlB[5] (pre-shift value, i.e. x[2m-11]).
  - FSM goes IDLE -> MAC.
- tapsum[k] = dlA[k] + dlA[11-k], k=0..5, 21-bit sign-extended.
- Coefficients c0..c5 = -183, 1321, -5334, 16030, -42993, 162229. Side taps sum to 0.5 and centre = 0.5, so DC gain = 1.
- FSM:
  - IDLE: waits for trigger; acc <= center_reg<<18 is loaded on the trigger edge.
  - MAC: k = 0..5, one per cycle; acc += c[k]*tapsum[k]. Product is 41-bit, sign-extended to AW. After k=5 -> ROUND.
  - ROUND: r = (acc + 2^18) >>> 19 (round half up). filter_out <= r saturated or wrapped to DW (see feature). ce_out <= 1 for exactly one cycle. -> IDLE.
- Latency: trigger accepted at edge N -> filter_out updated and ce_out high after edge N+8.
- Throughput:
  - Triggers must be >= 8 clocks apart.
  - A phase-B sample may arrive at any time; dlB shifting during MAC is safe because the centre is latched.
- Overrun: a trigger arriving while FSM != IDLE is handled as follows.
  - The sample is dropped (dlA unchanged) and phase still toggles.
  - overrun is set and stays high until reset.
  - The current computation completes normally.
- A trigger coinciding with the ROUND cycle counts as busy, i.e. overrun.
- Reset mid-MAC aborts the computation. No ce_out is issued.
- clk_enable low: no state changes except the FSM progressing.

Optional Feature:
- Macro HB_DECIM_SAT_EN.
- Defined: r is saturated to [-2^(DW-1), 2^(DW-1)-1].
- Undefined: r is truncated to its low DW bits (wrap). This saves comparator logic.

Decomposition:
- halfband_pkg holds:
  - coefficient constants C0..C5
  - width constants DW/CW/AW, ROUND_SHIFT=19, CENTER_SHIFT=18
  - FSM state enum {IDLE, MAC, ROUND}
- One natural sub-module: halfband_mac_core. It holds the accumulator, the coefficient mux indexed by k, and round/saturate. It is shared with the interpolator.
- Delay lines and phase control stay in the top level.

Test Plan:
1. Impulse on A:
   - Stimulus: reset, then pairs (B=0, A=262144), then zeros, triggers every 10 clocks.
   - Expected outputs: -91, 661, -2667, 8015, -21496, 81115, 81115, -21496, 8015, -2667, 661, -91, then 0.
2. Impulse on B:
   - Stimulus: B=262144 in the first pair, zeros after.
   - Expected: outputs 0,0,0,0,0, then 131072 on the 6th output, then 0.
3. DC: constant 100000 on all samples -> output settles to 99999 after 12 outputs.
4. Latency/strobe: check ce_out is high for exactly 1 cycle, 8 clocks after each trigger edge. filter_out must not change otherwise.
5. Overrun: a trigger 5 clocks after the previous one -> overrun=1 (sticky). The first output is still correct and the dropped sample does not enter dlA.
6. Saturation:
   - Stimulus: A samples ±524287/-524288 matching coefficient signs, with centre +524287.
   - With HB_DECIM_SAT_EN: output = 524287.
   - Without it: output = wrapped value. Also assert reset_n mid-MAC -> no ce_out, and all outputs = 0.
